// File: rtl/alu2_addsub.sv
// Registered WIDTH-bit two's-complement adder/subtractor with overflow, carry and zero flags.
// Optional build macro ALU2_SAT_EN: on signed overflow, Z saturates to the signed limit.
module alu2_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             add_sub,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] Z,
  output logic             ofs,
  output logic             carry,
  output logic             zero,
  output logic             out_valid
);

  // Handshake: valid-only, no ready. A cycle with in_valid=1 is consumed
  // unconditionally and its result shows with out_valid=1 on the next cycle only.

  logic [WIDTH-1:0] b_op;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] s_res;
  logic             ofs_next;
  logic [WIDTH-1:0] z_next;

  always_comb begin
    b_op     = add_sub ? ~Y : Y;
    sum      = {1'b0, X} + {1'b0, b_op} + {{WIDTH{1'b0}}, add_sub};
    s_res    = sum[WIDTH-1:0];
    ofs_next = (X[WIDTH-1] == b_op[WIDTH-1]) && (s_res[WIDTH-1] != X[WIDTH-1]);
`ifdef ALU2_SAT_EN
    // A positive X can only overflow upward, a negative X only downward.
    if (ofs_next)
      z_next = X[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    else
      z_next = s_res;
`else
    z_next = s_res;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Z         <= '0;
      ofs       <= 1'b0;
      carry     <= 1'b0;
      zero      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        Z     <= z_next;
        ofs   <= ofs_next;
        carry <= sum[WIDTH];
        zero  <= (z_next == '0);
      end
    end
  end

endmodule

// File: tb/tb_alu2_addsub.sv
// Self-checking bench for alu2_addsub: directed cases, back-to-back, random traffic
// and asynchronous reset with a result in flight. Honours ALU2_SAT_EN like the DUT.
module tb_alu2_addsub;
  localparam int W = 8;
  localparam int EW = W + 3;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         add_sub;
  logic [W-1:0] X;
  logic [W-1:0] Y;
  logic [W-1:0] Z;
  logic         ofs;
  logic         carry;
  logic         zero;
  logic         out_valid;

  int checks = 0;
  int failures = 0;

  // Packed {z, ofs, carry, zero}
  logic [EW-1:0] exp_q[$];

  alu2_addsub #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .add_sub(add_sub),
    .X(X), .Y(Y), .Z(Z), .ofs(ofs), .carry(carry), .zero(zero),
    .out_valid(out_valid)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [EW-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic as);
    int xs, ys, ux, uy, t;
    logic [W-1:0] z;
    logic o, c;
    xs = $signed(x);
    ys = $signed(y);
    ux = int'(x);
    uy = int'(y);
    t  = as ? (xs - ys) : (xs + ys);
    o  = (t > (2**(W-1) - 1)) || (t < -(2**(W-1)));
    c  = as ? (ux >= uy) : ((ux + uy) > (2**W - 1));
    z  = t[W-1:0];
`ifdef ALU2_SAT_EN
    if (o) z = (t > 0) ? W'(2**(W-1) - 1) : W'(2**(W-1));
`endif
    return {z, o, c, (z == '0)};
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_out: got Z=%h ofs=%b carry=%b zero=%b with no expected result",
                 Z, ofs, carry, zero);
      end else begin
        logic [EW-1:0] e;
        e = exp_q.pop_front();
        if ({Z, ofs, carry, zero} !== e) begin
          failures++;
          $display("FAIL result: got Z=%h ofs=%b carry=%b zero=%b, expected Z=%h ofs=%b carry=%b zero=%b",
                   Z, ofs, carry, zero, e[EW-1:3], e[2], e[1], e[0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic as);
    @(negedge clk);
    in_valid = 1'b1;
    X        = x;
    Y        = y;
    add_sub  = as;
    exp_q.push_back(model(x, y, as));
  endtask

  task automatic drive_idle();
    @(negedge clk);
    in_valid = 1'b0;
    X        = W'($urandom_range(0, 2**W - 1));
    Y        = W'($urandom_range(0, 2**W - 1));
    add_sub  = 1'($urandom_range(0, 1));
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    in_valid = 1'b0; add_sub = 1'b0; X = '0; Y = '0;
    rst_n = 1'b0;
    #3;
    checks++;
    if ({Z, ofs, carry, zero, out_valid} !== '0) begin
      failures++;
      $display("FAIL reset_state: got Z=%h ofs=%b carry=%b zero=%b out_valid=%b, expected all 0",
               Z, ofs, carry, zero, out_valid);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single(input logic [W-1:0] x, input logic [W-1:0] y, input logic as);
    drive_op(x, y, as);
    drive_idle();
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL single_latency: out_valid=%b one cycle after op, expected 1", out_valid);
    end
    drive_idle();
    checks++;
    if (out_valid !== 1'b0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL single_done: out_valid=%b pending=%0d, expected out_valid=0 pending=0",
               out_valid, exp_q.size());
    end
  endtask

  task automatic test_spec_cases();
    test_single(8'hFF, 8'hE0, 1'b1);
    test_single(8'hAA, 8'hAA, 1'b1);
    test_single(8'h6A, 8'h6A, 1'b0);
    test_single(8'h80, 8'h01, 1'b1);
    test_single(8'h7F, 8'h01, 1'b0);
    test_single(8'h00, 8'h00, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] hold_z;
`ifdef ALU2_SAT_EN
    hold_z = 8'h7F;
`else
    hold_z = 8'hD4;
`endif
    drive_op(8'hFF, 8'hE0, 1'b1);
    drive_op(8'hAA, 8'hAA, 1'b1);
    for (int i = 0; i < 2; i++) begin
      if (i == 0) drive_op(8'h6A, 8'h6A, 1'b0);
      else        drive_idle();
      checks++;
      if (out_valid !== 1'b1) begin
        failures++;
        $display("FAIL b2b_valid: out_valid=%b at stream cycle %0d, expected 1", out_valid, i);
      end
    end
    drive_idle();
    checks++;
    if (out_valid !== 1'b0 || Z !== hold_z || ofs !== 1'b1 || carry !== 1'b0 || zero !== 1'b0) begin
      failures++;
      $display("FAIL b2b_hold: out_valid=%b Z=%h ofs=%b carry=%b zero=%b, expected 0 %h 1 0 0",
               out_valid, Z, ofs, carry, zero, hold_z);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL b2b_drain: pending=%0d, expected 0", exp_q.size());
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0)
        drive_idle();
      else
        drive_op(W'($urandom_range(0, 2**W - 1)), W'($urandom_range(0, 2**W - 1)),
                 1'($urandom_range(0, 1)));
    end
    drive_idle();
    drive_idle();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL random_drain: pending=%0d, expected 0", exp_q.size());
    end
  endtask

  task automatic test_reset_inflight();
    drive_op(8'h6A, 8'h6A, 1'b0);
    drive_op(8'h12, 8'h34, 1'b0);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    checks++;
    if ({Z, ofs, carry, zero, out_valid} !== '0) begin
      failures++;
      $display("FAIL reset_async: got Z=%h ofs=%b carry=%b zero=%b out_valid=%b, expected all 0",
               Z, ofs, carry, zero, out_valid);
    end
    drive_idle();
    drive_idle();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_idle();
      checks++;
      if (out_valid !== 1'b0 || Z !== '0) begin
        failures++;
        $display("FAIL reset_discard: out_valid=%b Z=%h after release cycle %0d, expected 0 00",
                 out_valid, Z, i);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_spec_cases();
    test_back_to_back();
    test_random();
    test_reset_inflight();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
